gray_decode_tracker: RTL and testbench
======================================

GRAY_DECODE_TRACKER -- requirements
Module: gray_decode_tracker

Interface
REQ-001 Parameter W, default 3, SHALL set the Gray/binary word width (legal range 2..16).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 Port clr  input  1  SHALL be a synchronous soft clear, active-high.
REQ-005 Port g_in  input  W  SHALL carry the Gray-coded sample, MSB = g_in[W-1].
REQ-006 Port g_valid  input  1  SHALL qualify g_in; sampled on every edge where high.
REQ-007 Port b_out  output  W  SHALL carry the decoded binary value of the last accepted sample.
REQ-008 Port b_valid  output  1  SHALL pulse high for one cycle per decoded sample.
REQ-009 Port dir_up  output  1  SHALL pulse with b_valid when the step is +1 mod 2^W.
REQ-010 Port dir_dn  output  1  SHALL pulse with b_valid when the step is -1 mod 2^W.
REQ-011 Port step_err  output  1  SHALL pulse with b_valid when the step is neither 0, +1 nor -1.
REQ-012 Port pos  output  16  SHALL be the signed two's-complement position accumulator.
REQ-013 Port err_cnt  output  8  SHALL count step errors, saturating at 255.

Function
REQ-014 Decode SHALL be b[W-1]=g[W-1]; b[i]=b[i+1] XOR g[i] for i=W-2..0.
REQ-015 Pipeline SHALL be two stages: stage 1 registers g_in when g_valid=1; stage 2 decodes, compares and registers outputs.
REQ-016 Latency SHALL be 2 cycles: g_valid high at edge N -> b_valid, b_out, flags valid in the cycle after edge N+1.
REQ-017 Back-to-back g_valid on consecutive cycles SHALL be accepted at full rate, one b_valid per input.
REQ-018 FSM SHALL have states UNPRIMED and TRACK; reset and clr enter UNPRIMED.
REQ-019 UNPRIMED: first decoded sample SHALL set b_out and prev, assert b_valid, assert no direction/error flag, leave pos unchanged, then go to TRACK.
REQ-020 TRACK: delta = (b_new - prev) mod 2^W; 0 -> b_valid only; 1 -> dir_up, pos+1; 2^W-1 -> dir_dn, pos-1; else step_err, err_cnt+1 (saturating), pos unchanged.
REQ-021 prev SHALL update to b_new on every decoded sample, including error samples.
REQ-022 pos SHALL wrap modulo 2^16 (32767+1 -> -32768, -32768-1 -> 32767).
REQ-023 Code wrap (binary 2^W-1 -> 0) SHALL count as +1; 0 -> 2^W-1 as -1.
REQ-024 dir_up, dir_dn, step_err SHALL be mutually exclusive and SHALL only be high while b_valid=1.
REQ-025 clr SHALL clear pos, err_cnt, b_valid, all flags and both pipeline stages, and enter UNPRIMED; b_out SHALL hold its value.
REQ-026 clr and g_valid on the same edge: clr SHALL win; the sample SHALL be dropped.
REQ-027 A sample in stage 1 when clr asserts SHALL be discarded (no b_valid produced).
REQ-028 For W=2, delta 2 SHALL be step_err.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force b_out=0, b_valid=0, dir_up=0, dir_dn=0, step_err=0, pos=0, err_cnt=0, prev=0, pipeline empty, state UNPRIMED.
REQ-030 rst_n SHALL take priority over clr and g_valid; reset mid-stream SHALL drop in-flight samples.
REQ-031 Outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (W=3)
REQ-032 Gray 000,001,011,010,110,111,101,100 on consecutive cycles -> b_out 0..7, 8 b_valid pulses, 7 dir_up, pos=7, latency 2 cycles each.
REQ-033 After REQ-032, g_in=000 -> b_out=0, dir_up, pos=8 (wrap counted +1); then 100 -> b_out=7, dir_dn, pos=7.
REQ-034 Prime with 000, then 011 -> b_out=2, step_err, err_cnt=1, pos unchanged; then 010 -> b_out=3, dir_up (prev was 2).
REQ-035 Repeat 001 twice after priming -> second sample b_valid only, no flags, pos unchanged; 256 error steps -> err_cnt holds 255.
REQ-036 clr asserted with g_valid on the same edge, then 001 -> no b_valid for dropped sample; 001 primes (no flag), pos=0, err_cnt=0.
REQ-037 rst_n low one cycle while a sample is in stage 1 -> no b_valid emerges, all outputs 0, next sample primes.

Source files
------------

// File: rtl/gray_decode_tracker.sv
// Gray-code decoder and quadrature-style position tracker.
// Stage 1 captures qualified Gray samples. Stage 2 decodes each sample to binary and classifies
// the step from the previous sample as hold, +1, -1 or error. It then updates a wrapping signed
// position and a saturating error counter. All outputs come straight from registers.
module gray_decode_tracker #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] g_in,
   input  logic         g_valid,
   output logic [W-1:0] b_out,
   output logic         b_valid,
   output logic         dir_up,
   output logic         dir_dn,
   output logic         step_err,
   output logic [15:0]  pos,
   output logic [7:0]   err_cnt
);

   // Step classes as W-bit constants; +1 and -1 are distinct for every legal W >= 2.
   localparam logic [W-1:0] StepZero = '0;
   localparam logic [W-1:0] StepUp   = W'(1);
   localparam logic [W-1:0] StepDn   = {W{1'b1}};

   typedef enum logic [0:0] {
      StUnprimed,
      StTrack
   } state_e;

   // Stage 1 registers.
   logic         s1_valid_q;
   logic [W-1:0] s1_gray_q;

   // Stage 2 state and output registers.
   state_e       state_q;
   logic [W-1:0] prev_q;
   logic [W-1:0] b_out_q;
   logic         b_valid_q;
   logic         dir_up_q;
   logic         dir_dn_q;
   logic         step_err_q;
   logic [15:0]  pos_q;
   logic [7:0]   err_cnt_q;

   // Combinational decode of the stage-1 sample.
   logic [W-1:0] b_new;
   logic [W-1:0] delta;

   // Stage 1: capture a sample on every edge where g_valid is high; clr or reset flush it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_gray_q  <= '0;
      end else if (clr) begin
         s1_valid_q <= 1'b0;
         s1_gray_q  <= '0;
      end else begin
         s1_valid_q <= g_valid;
         if (g_valid) begin
            s1_gray_q <= g_in;
         end
      end
   end

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      b_new        = '0;
      b_new[W-1]   = s1_gray_q[W-1];
      for (int i = int'(W) - 2; i >= 0; i--) begin
         b_new[i] = b_new[i+1] ^ s1_gray_q[i];
      end
      // Modular difference; the natural W-bit wrap makes 2^W-1 -> 0 read as +1.
      delta = b_new - prev_q;
   end

   // Stage 2: tracker FSM with registered outputs, flags pulsed for one cycle per sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StUnprimed;
         prev_q     <= '0;
         b_out_q    <= '0;
         b_valid_q  <= 1'b0;
         dir_up_q   <= 1'b0;
         dir_dn_q   <= 1'b0;
         step_err_q <= 1'b0;
         pos_q      <= '0;
         err_cnt_q  <= '0;
      end else if (clr) begin
         // b_out deliberately holds; a sample still in stage 1 is dropped here.
         state_q    <= StUnprimed;
         b_valid_q  <= 1'b0;
         dir_up_q   <= 1'b0;
         dir_dn_q   <= 1'b0;
         step_err_q <= 1'b0;
         pos_q      <= '0;
         err_cnt_q  <= '0;
      end else begin
         b_valid_q  <= s1_valid_q;
         dir_up_q   <= 1'b0;
         dir_dn_q   <= 1'b0;
         step_err_q <= 1'b0;
         if (s1_valid_q) begin
            b_out_q <= b_new;
            prev_q  <= b_new;
            unique case (state_q)
               StUnprimed: begin
                  // First sample only establishes the reference point.
                  state_q <= StTrack;
               end
               StTrack: begin
                  if (delta == StepUp) begin
                     dir_up_q <= 1'b1;
                     pos_q    <= pos_q + 16'd1;
                  end else if (delta == StepDn) begin
                     dir_dn_q <= 1'b1;
                     pos_q    <= pos_q - 16'd1;
                  end else if (delta != StepZero) begin
                     step_err_q <= 1'b1;
                     if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                     end
                  end
               end
               default: begin
                  state_q <= StUnprimed;
               end
            endcase
         end
      end
   end

   assign b_out    = b_out_q;
   assign b_valid  = b_valid_q;
   assign dir_up   = dir_up_q;
   assign dir_dn   = dir_dn_q;
   assign step_err = step_err_q;
   assign pos      = pos_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Testbench for gray_decode_tracker (W=3).
// Directed sequences are followed by randomized traffic. Every cycle is compared against a
// sample-level reference model that tracks in-flight samples by due cycle.
module tb_gray_decode_tracker;

   localparam int unsigned W = 3;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic [W-1:0] g_in;
   logic         g_valid;
   logic [W-1:0] b_out;
   logic         b_valid;
   logic         dir_up;
   logic         dir_dn;
   logic         step_err;
   logic [15:0]  pos;
   logic [7:0]   err_cnt;

   always #5 clk = ~clk;

   gray_decode_tracker #(
      .W (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .g_in     (g_in),
      .g_valid  (g_valid),
      .b_out    (b_out),
      .b_valid  (b_valid),
      .dir_up   (dir_up),
      .dir_dn   (dir_dn),
      .step_err (step_err),
      .pos      (pos),
      .err_cnt  (err_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state.
   typedef struct {
      int           due;
      logic [W-1:0] g;
   } samp_t;
   samp_t       pend[$];
   bit          m_primed;
   int          m_prev;
   int          m_bout;
   logic [15:0] m_pos;
   int          m_err;
   bit          m_bv, m_up, m_dn, m_se;
   int          last_b;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int gray2bin(input int g);
      int b = 0;
      for (int s = 0; s < int'(W); s++) b = b ^ (g >> s);
      return b % M;
   endfunction

   function automatic int bin2gray(input int b);
      return (b ^ (b >> 1)) % M;
   endfunction

   // Advance the model by one rising edge with the inputs that edge sees.
   task automatic model_edge(input logic r, input logic c, input logic gv, input logic [W-1:0] gi);
      samp_t s;
      int    b;
      int    d;
      cyc++;
      if (!r) begin
         pend.delete();
         m_primed = 0; m_prev = 0; m_bout = 0; m_pos = '0; m_err = 0;
         m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
         return;
      end
      if (c) begin
         pend.delete();
         m_primed = 0; m_pos = '0; m_err = 0;
         m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
         return;
      end
      m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         s = pend.pop_front();
         b = gray2bin(int'(s.g));
         d = (b - m_prev + M) % M;
         m_bv   = 1;
         m_bout = b;
         if (m_primed) begin
            if (d == 1) begin
               m_up = 1; m_pos = m_pos + 16'd1;
            end else if (d == M - 1) begin
               m_dn = 1; m_pos = m_pos - 16'd1;
            end else if (d != 0) begin
               m_se = 1;
               if (m_err < 255) m_err++;
            end
         end
         m_primed = 1;
         m_prev   = b;
      end
      if (gv) pend.push_back('{cyc + 1, gi});
   endtask

   task automatic step(input logic r, input logic c, input logic gv, input logic [W-1:0] gi);
      @(negedge clk);
      rst_n = r; clr = c; g_valid = gv; g_in = gi;
      @(posedge clk);
      model_edge(r, c, gv, gi);
      #1;
      check_eq("b_out",    32'(b_out),    32'(m_bout));
      check_eq("b_valid",  32'(b_valid),  32'(m_bv));
      check_eq("dir_up",   32'(dir_up),   32'(m_up));
      check_eq("dir_dn",   32'(dir_dn),   32'(m_dn));
      check_eq("step_err", 32'(step_err), 32'(m_se));
      check_eq("pos",      32'(pos),      32'(m_pos));
      check_eq("err_cnt",  32'(err_cnt),  32'(m_err));
   endtask

   task automatic send_bin(input int b);
      step(1'b1, 1'b0, 1'b1, W'(bin2gray(b)));
      last_b = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      int nb;
      int kind;
      logic r, c, gv;
      rst_n = 1'b0; clr = 1'b0; g_valid = 1'b0; g_in = '0; last_b = 0;
      do_reset();
      do_reset();

      // Full count 0..7, then wrap up to 0 and back down to 7.
      for (int b = 0; b < M; b++) send_bin(b);
      send_bin(0);
      send_bin(7);
      idle(3);

      // Prime, jump by 2 (error), then +1 from the erroneous value.
      do_reset();
      send_bin(0);
      send_bin(2);
      send_bin(3);
      idle(3);

      // Repeated sample holds; then a long run of +2 steps to saturate err_cnt.
      do_reset();
      send_bin(1);
      send_bin(1);
      for (int i = 0; i < 262; i++) send_bin((2 * i) % M);
      idle(3);

      // clr together with g_valid drops that sample; next sample primes.
      step(1'b1, 1'b1, 1'b1, W'(bin2gray(5)));
      send_bin(1);
      idle(3);

      // clr while a sample sits in stage 1.
      send_bin(2);
      send_bin(4);
      step(1'b1, 1'b1, 1'b0, '0);
      idle(3);

      // Reset while a sample sits in stage 1.
      send_bin(0);
      send_bin(1);
      do_reset();
      idle(2);
      send_bin(3);
      send_bin(4);
      idle(3);

      // Randomized traffic biased toward legal steps.
      for (int i = 0; i < 1200; i++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 2)      nb = (last_b + 1) % M;
         else if (kind <= 5) nb = (last_b + M - 1) % M;
         else if (kind == 6) nb = last_b;
         else                nb = $urandom_range(0, M - 1);
         gv = ($urandom_range(0, 9) < 7);
         c  = ($urandom_range(0, 39) == 0);
         r  = !($urandom_range(0, 79) == 0);
         step(r, c, gv, W'(bin2gray(nb)));
         if (gv) last_b = nb;
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
